// File: rtl/reg_select_pkg.sv
// Shared definitions for the register-select decoder: mode encodings,
// controller states and a one-hot helper.
package reg_select_pkg;

    // Decode mode encodings as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SWEEP = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Controller states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    // One-hot vector with bit 'index' set; all-zero when index is outside
    // the vector width (or beyond the 64-bit return width).
    function automatic logic [63:0] onehot(input int unsigned index,
                                           input int unsigned width);
        logic [63:0] v;
        v = '0;
        if (index < width && index < 64)
            v = 64'(1) << index;
        return v;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Registered one-hot register-enable decoder with level, pulse and sweep
// modes. Outputs are fully registered; the sweep is a two-state controller.
module reg_select_decoder
    import reg_select_pkg::*;
#(
    parameter int unsigned N_OUT = 16,
    parameter int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [SEL_W-1:0] sel,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [N_OUT-1:0] dec_out,
    output logic             busy,
    output logic             sweep_done,
    output logic             sel_err
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             en_q;
    logic [N_OUT-1:0] dec_d;
    logic             busy_d, done_d, err_d;
    logic             sel_ok;

    assign sel_ok = (32'(sel) < N_OUT);

    // Next-state and next-output decode; every output defaults to idle/zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (mode_e'(mode))
                    MODE_LEVEL: begin
                        if (enable) begin
                            if (sel_ok) dec_d = N_OUT'(onehot(32'(sel), N_OUT));
                            else        err_d = 1'b1;
                        end
                    end
                    MODE_PULSE: begin
                        if (enable && !en_q) begin
                            if (sel_ok) dec_d = N_OUT'(onehot(32'(sel), N_OUT));
                            else        err_d = 1'b1;
                        end
                    end
                    MODE_SWEEP: begin
                        if (start) begin
                            state_d = ST_SWEEP;
                            cnt_d   = '0;
                            dec_d   = N_OUT'(onehot(0, N_OUT));
                            busy_d  = 1'b1;
                        end
                    end
                    MODE_RSVD: begin
                    end
                    default: begin
                    end
                endcase
            end
            ST_SWEEP: begin
                // Terminate on the last valid index rather than counter wrap so
                // non-power-of-two widths end correctly.
                if (cnt_q == SEL_W'(N_OUT - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + SEL_W'(1);
                    dec_d  = N_OUT'(onehot(32'(cnt_d), N_OUT));
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, previous-enable and registered outputs; clear wins.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            en_q       <= 1'b0;
            dec_out    <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            en_q       <= enable;
            dec_out    <= dec_d;
            busy       <= busy_d;
            sweep_done <= done_d;
            sel_err    <= err_d;
        end
    end

endmodule

// File: doc/reg_select_decoder.md
REG_SELECT_DECODER -- requirements
Module: reg_select_decoder

Interface
REQ-001 SHALL have parameter N_OUT, default 16, number of one-hot outputs (2..64).
REQ-002 SHALL have parameter SEL_W, default $clog2(N_OUT), select-field width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  decode request qualifier.
REQ-006 SHALL have port sel  input  SEL_W  register index to decode.
REQ-007 SHALL have port mode  input  2  00 level, 01 pulse, 10 sweep, 11 reserved.
REQ-008 SHALL have port start  input  1  sweep launch strobe (mode 10 only).
REQ-009 SHALL have port dec_out  output  N_OUT  registered one-hot register-enable vector.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port sweep_done  output  1  one-cycle pulse at sweep completion.
REQ-012 SHALL have port sel_err  output  1  one-cycle pulse when sel >= N_OUT is requested.

Function
REQ-013 SHALL implement states IDLE and SWEEP; IDLE handles modes 00/01/11.
REQ-014 Level mode (00): dec_out SHALL equal onehot(sel) one cycle after enable=1, and all-zero one cycle after enable=0; latency 1.
REQ-015 Pulse mode (01): a 0->1 transition of enable SHALL produce onehot(sel) on dec_out for exactly one cycle, then zero; enable held high SHALL NOT retrigger.
REQ-016 Pulse-mode edge detection SHALL use the registered previous enable, which updates in every mode and state.
REQ-017 Mode 11: dec_out SHALL be all-zero; no other output asserts.
REQ-018 Any decode request (level: enable=1; pulse: enable rising) with sel >= N_OUT SHALL give dec_out all-zero and sel_err=1 next cycle for one cycle; level mode re-pulses sel_err each cycle the condition holds.
REQ-019 Sweep mode (10): start=1 in IDLE SHALL enter SWEEP next cycle with busy=1 and dec_out=bit 0; dec_out SHALL advance one bit per cycle to bit N_OUT-1.
REQ-020 The cycle after dec_out=bit N_OUT-1, state SHALL return to IDLE with dec_out=0, busy=0, sweep_done=1 for exactly one cycle; sweep occupies exactly N_OUT cycles of busy.
REQ-021 In SWEEP, enable, sel, mode and start SHALL be ignored; start during SWEEP SHALL NOT restart or extend the sweep.
REQ-022 start=1 with mode != 10 SHALL be ignored.
REQ-023 Sweep index counter SHALL be SEL_W bits, compared against N_OUT-1 (not wrap), so non-power-of-two N_OUT terminates correctly.
REQ-024 dec_out SHALL never have more than one bit set in any cycle.
REQ-025 Mode change in IDLE SHALL take effect on the next edge without glitch cycles of stale one-hot.

Reset
REQ-026 clear=1 SHALL force on the next edge: state IDLE, dec_out=0, busy=0, sweep_done=0, sel_err=0, sweep counter=0, previous-enable register=0.
REQ-027 clear SHALL have priority over all inputs, including mid-sweep; an aborted sweep SHALL NOT assert sweep_done.
REQ-028 First edge after clear deasserts SHALL process inputs normally (enable high then counts as a rising edge in pulse mode).

Structure
REQ-029 Package reg_select_pkg SHALL hold the mode encoding constants, state enum and a onehot(index, width) function.
REQ-030 No sub-module; single module with one sequential process and combinational next-state logic.

Verification
REQ-031 Level: N_OUT=16, mode=00, enable=1, sel=4'h5 -> dec_out=16'h0020 next cycle; enable=0 -> 16'h0000 next cycle.
REQ-032 Pulse: mode=01, sel=4'hF, enable high 4 cycles -> dec_out=16'h8000 exactly one cycle, then 0; drop and re-raise enable -> second single pulse.
REQ-033 Sweep: mode=10, start 1 cycle -> dec_out 16'h0001,0002,...,8000 over 16 cycles with busy=1, then sweep_done=1 one cycle, dec_out=0; start asserted at cycle 5 ignored.
REQ-034 Range: N_OUT=10, SEL_W=4, mode=00, enable=1, sel=4'hC -> dec_out=0, sel_err=1; sweep with N_OUT=10 ends after bit 9, busy exactly 10 cycles.
REQ-035 Reset mid-sweep: clear=1 at sweep cycle 7 -> next cycle dec_out=0, busy=0, sweep_done stays 0; subsequent level decode sel=4'h3 -> 16'h0008.
